mul2_signed_arbiter: RTL
========================

MUL2_SIGNED_ARBITER -- requirements
Module: mul2_signed_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the multiplier; the design SHALL support 2..8.
REQ-002 Parameter IDW, default 2, requester-ID width; it SHALL equal $clog2(NREQ).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operand valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit SHALL be high in any cycle.
REQ-007 req_a  input  2*NREQ  packed signed 2-bit multiplicands; requester i uses bits [2i+1:2i].
REQ-008 req_b  input  2*NREQ  packed signed 2-bit multipliers, packed the same way as req_a.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_out  output  4  signed product, two's complement.
REQ-012 rsp_id  output  IDW  index of the requester that owns rsp_out.

Function
REQ-013 A request transfers when req_valid[i] and req_ready[i] are both high; a response transfers when rsp_valid and rsp_ready are both high.
REQ-014 The block SHALL contain one shared 2x2 signed multiplier (combinational) and one output holding register: {rsp_out, rsp_id, rsp_valid}.
REQ-015 Slot free = !rsp_valid || rsp_ready; req_ready SHALL be all-zero when the slot is not free.
REQ-016 When the slot is free, req_ready SHALL be one-hot on the first asserted req_valid bit found searching upward (with wrap) from rr_ptr.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr, rsp_valid and rsp_ready.
REQ-018 A request accepted in cycle N SHALL appear on rsp_out/rsp_id with rsp_valid=1 in cycle N+1 (latency 1).
REQ-019 Simultaneous response drain and new accept in the same cycle SHALL load the new result; one result per cycle is sustained throughput.
REQ-020 Drain with no accept SHALL clear rsp_valid next cycle.
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_out and rsp_id SHALL hold stable.
REQ-022 rr_ptr (IDW bits) SHALL update on each accept to (granted index + 1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-023 rr_ptr SHALL hold when there is no accept.
REQ-024 Fairness: a continuously valid requester SHALL be granted within NREQ accepts.
REQ-025 Product range: -2*-2=+4 (0100) is the only positive maximum; result SHALL be exact across all 16 operand pairs.
REQ-026 req_valid bits at index >= NREQ do not exist; unused rr_ptr codes (NREQ not a power of 2) SHALL never be produced.
REQ-027 Deasserting req_valid without a transfer is legal and SHALL have no side effect.

Reset
REQ-028 While rst_n=0: rsp_valid=0, rsp_out=0, rsp_id=0, rr_ptr=0, req_ready=0, asserted asynchronously.
REQ-029 Reset mid-operation SHALL discard any held result; the first grant after release SHALL search from index 0.
REQ-030 Reset release SHALL be taken synchronously to clk by the integrating design; the block SHALL not self-synchronise.

Structure
REQ-031 The shared package SHALL hold MUL2_W=2, PROD_W=4 and the default NREQ.
REQ-032 The multiplier SHALL be the existing mul2_signed, instantiated once as the sole sub-module.
REQ-033 Arbiter and holding register SHALL be in this module; no other sub-modules.

Verification
REQ-034 After reset, all req_valid=1, rsp_ready=1, operands a=11, b=11 -> rsp_id 0,1,2,3,0 on consecutive cycles, rsp_out=0001 each cycle.
REQ-035 req_valid[2]=1, a=10, b=01, rsp_ready=1 -> rsp_out=1110, rsp_id=2 one cycle after accept.
REQ-036 a=10, b=10 -> rsp_out=0100.
REQ-037 Exhaustive 16 operand pairs on requester 1 -> rsp_out equals the signed product each time.
REQ-038 rsp_ready=0 for 3 cycles with a result held -> req_ready=0 and rsp_out/rsp_id stable; rsp_ready=1 -> drain plus new accept in the same cycle.
REQ-039 rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/mul2_signed_arbiter_pkg.sv
// mul2_signed_arbiter_pkg: shared widths and defaults for the arbitrated 2x2 signed multiplier
//   MUL2_W       operand width of the shared multiplier
//   PROD_W       width of the signed product
//   NREQ_DEFAULT default number of requesters
package mul2_signed_arbiter_pkg;
    localparam int MUL2_W       = 2;
    localparam int PROD_W       = 4;
    localparam int NREQ_DEFAULT = 4;
endpackage

// File: rtl/mul2_signed_arbiter_mul2_signed.sv
// mul2_signed: combinational 2x2 signed multiplier
//   a, b  signed 2-bit operands
//   p     signed 4-bit product (exact for every operand pair)
module mul2_signed
    import mul2_signed_arbiter_pkg::*;
(
    input  logic signed [MUL2_W-1:0] a,
    input  logic signed [MUL2_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);
    // sign-extend before multiplying so the truncated product stays exact
    assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/mul2_signed_arbiter.sv
// mul2_signed_arbiter: round-robin arbiter sharing one 2x2 signed multiplier behind a one-entry result register
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b          packed signed 2-bit operands, requester i at [2i+1:2i]
//   rsp_valid/rsp_ready   result handshake
//   rsp_out, rsp_id       signed product and owning requester index
module mul2_signed_arbiter
    import mul2_signed_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [MUL2_W*NREQ-1:0]   req_a,
    input  logic [MUL2_W*NREQ-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PROD_W-1:0]        rsp_out,
    output logic [IDW-1:0]           rsp_id
);
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, grant_idx, cand;
    logic [PROD_W-1:0] rsp_out_q, rsp_out_d, prod;
    logic [MUL2_W-1:0] op_a, op_b;
    logic              rsp_valid_q, rsp_valid_d, found, slot_free, accept;

    // scan downward in offset so the nearest valid requester at/after rr_ptr wins
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                op_a = req_a[k*MUL2_W +: MUL2_W];
                op_b = req_b[k*MUL2_W +: MUL2_W];
            end
        end
    end

    mul2_signed u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // rst_n gates the grant so req_ready is held low during reset
    always_comb begin
        slot_free   = !rsp_valid_q || rsp_ready;
        accept      = rst_n && slot_free && found;
        req_ready   = accept ? NREQ'(1) << grant_idx : '0;
        rsp_valid_d = accept ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_out_d   = accept ? prod : rsp_out_q;
        rsp_id_d    = accept ? grant_idx : rsp_id_q;
        rr_ptr_d    = accept ? ((grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_id    = rsp_id_q;
endmodule
